// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C write-only target: receiver state encoding,
// address/byte widths and the default synchronizer depth.
// ---------------------------------------------------------------------------
package i2c_pkg;

  localparam int I2C_ADDR_W          = 7;
  localparam int I2C_BYTE_W          = 8;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Receiver protocol states
  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// ---------------------------------------------------------------------------
// i2c_line_sync
// Brings one asynchronous bus line (SCL or SDA) into the system clock domain
// and reports its level and single-cycle edge strobes.
//
// Ports
//   clk_i    system clock
//   reset_i  synchronous active-high reset; all flops reset to 1 (idle bus)
//   line_i   raw asynchronous bus line
//   level_o  synchronized level (current sample)
//   rise_o   previous sample 0, current sample 1
//   fall_o   previous sample 1, current sample 0
// ---------------------------------------------------------------------------
module i2c_line_sync
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Synchronizer chain followed by a history flop. Resetting to 1 matches an
  // idle bus so that releasing reset cannot fabricate an SDA fall under a
  // high SCL (a false START).
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = ~hist_q &  level_o;
  assign fall_o  =  hist_q & ~level_o;

endmodule

// File: rtl/i2c_slave_receiver.sv
// ---------------------------------------------------------------------------
// i2c_slave_receiver
// Single-address, write-only I2C target. Oversamples SCL/SDA, detects
// START/STOP, matches the 7-bit address, drives ACK and presents each
// received data byte in parallel with a one-cycle valid strobe.
//
// Ports
//   clk_i         system clock (at least 10x the SCL frequency)
//   reset_i       synchronous active-high reset
//   scl_i         bus clock, asynchronous
//   sda_i         bus data as read from the pad, asynchronous
//   sda_drive_o   1 = pull SDA low (open-drain enable), 0 = release
//   data_out_o    last received data byte (MSB first on the wire)
//   data_valid_o  one-cycle pulse when data_out_o updates
//   busy_o        high from address ACK until STOP, repeated START or reset
//   stop_seen_o   one-cycle pulse on every detected STOP
// ---------------------------------------------------------------------------
module i2c_slave_receiver
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h48,
  parameter int                    SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_drive_o,
  output logic [I2C_BYTE_W-1:0] data_out_o,
  output logic                  data_valid_o,
  output logic                  busy_o,
  output logic                  stop_seen_o
);

  logic sclLevel, sclRise, sclFall;
  logic sdaLevel, sdaRise, sdaFall;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .line_i  (scl_i),
    .level_o (sclLevel),
    .rise_o  (sclRise),
    .fall_o  (sclFall)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .line_i  (sda_i),
    .level_o (sdaLevel),
    .rise_o  (sdaRise),
    .fall_o  (sdaFall)
  );

  i2c_state_e            state_q;
  logic [2:0]            bit_cnt_q;
  logic [I2C_BYTE_W-1:0] shift_q;
  logic [I2C_BYTE_W-1:0] shift_d;
  logic                  sda_drive_q;
  logic [I2C_BYTE_W-1:0] data_out_q;
  logic                  data_valid_q;
  logic                  busy_q;
  logic                  stop_seen_q;

  logic sclHighStable;
  logic startDet;
  logic stopDet;

  // SCL high in both prev and cur is "high now and not a rise this cycle".
  // Because this excludes any SCL edge, an SDA edge coinciding with an SCL
  // edge can never be taken for START/STOP.
  assign sclHighStable = sclLevel & ~sclRise;
  assign startDet      = sclHighStable & sdaFall;
  assign stopDet       = sclHighStable & sdaRise;

  // Shift register next value: new bit enters at the LSB, so the first bit
  // on the wire ends up as the MSB.
  always_comb begin
    shift_d = {shift_q[I2C_BYTE_W-2:0], sdaLevel};
  end

  // Protocol FSM. STOP and START take priority over everything else and
  // abandon whatever was in progress. In the two ACK states sda_drive_q
  // doubles as the phase flag: the first SCL fall pulls SDA low, the second
  // releases it and moves on to the next data byte.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= '0;
      sda_drive_q  <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      stop_seen_q  <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      stop_seen_q  <= stopDet;
      if (stopDet || startDet) begin
        state_q     <= stopDet ? IDLE : ADDR;
        bit_cnt_q   <= 3'd0;
        shift_q     <= '0;
        sda_drive_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
          end
          ADDR: begin
            if (sclRise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              // On the 8th bit, shift_q holds the 7 address bits and the
              // bit being sampled now is R/W.
              if (bit_cnt_q == 3'd7) begin
                if (shift_q[I2C_ADDR_W-1:0] == SLAVE_ADDR && !sdaLevel) begin
                  state_q <= ADDR_ACK;
                end else begin
                  state_q <= IGNORE;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (sclFall) begin
              if (!sda_drive_q) begin
                sda_drive_q <= 1'b1;
                busy_q      <= 1'b1;
              end else begin
                sda_drive_q <= 1'b0;
                bit_cnt_q   <= 3'd0;
                state_q     <= DATA;
              end
            end
          end
          DATA: begin
            if (sclRise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q <= DATA_ACK;
              end
            end
          end
          DATA_ACK: begin
            if (sclFall) begin
              if (!sda_drive_q) begin
                sda_drive_q  <= 1'b1;
                data_out_q   <= shift_q;
                data_valid_q <= 1'b1;
              end else begin
                sda_drive_q <= 1'b0;
                bit_cnt_q   <= 3'd0;
                state_q     <= DATA;
              end
            end
          end
          IGNORE: begin
            sda_drive_q <= 1'b0;
          end
          default: begin
            state_q     <= IDLE;
            sda_drive_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_drive_o  = sda_drive_q;
  assign data_out_o   = data_out_q;
  assign data_valid_o = data_valid_q;
  assign busy_o       = busy_q;
  assign stop_seen_o  = stop_seen_q;

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_receiver
// Self-checking bench for i2c_slave_receiver. A bus-master model issues
// START/STOP and bytes; expected ACKs, received bytes and pulse counts come
// from transaction-level rules (address match and R/W bit).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_slave_receiver;

  localparam logic [6:0] SLAVE = 7'h48;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sdaM = 1'b1;
  logic       sdaLine;
  logic       sdaDrive;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       busy;
  logic       stopSeen;

  int checks = 0;
  int errors = 0;

  // Open-drain wired-AND of master and target
  assign sdaLine = sdaM & ~sdaDrive;

  i2c_slave_receiver #(.SLAVE_ADDR(SLAVE), .SYNC_STAGES(2)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .scl_i        (scl),
    .sda_i        (sdaLine),
    .sda_drive_o  (sdaDrive),
    .data_out_o   (dataOut),
    .data_valid_o (dataValid),
    .busy_o       (busy),
    .stop_seen_o  (stopSeen)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  // Hard stop in case the bench itself ever stalls
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 5 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: cumulative counts of output activity, sampled on the falling
  // clock edge away from the DUT's update edge
  int         rxCount = 0;
  int         stopCount = 0;
  int         driveCount = 0;
  int         busyCount = 0;
  int         validWidthErr = 0;
  logic       prevValid = 1'b0;
  logic [7:0] rxLog [0:1023];

  always @(negedge clk) begin
    if (dataValid === 1'b1) begin
      rxLog[rxCount[9:0]] = dataOut;
      rxCount++;
      if (prevValid === 1'b1) validWidthErr++;
    end
    prevValid = dataValid;
    if (stopSeen === 1'b1) stopCount++;
    if (sdaDrive === 1'b1) driveCount++;
    if (busy === 1'b1) busyCount++;
  end

  logic [7:0] txData [0:3];

  // One comparison: counts it and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive both bus lines, then hold for a number of clock cycles
  task automatic applyStimulus(input logic sclV, input logic sdaV, input int hold);
    scl  = sclV;
    sdaM = sdaV;
    repeat (hold) @(negedge clk);
  endtask

  task automatic i2cStart();
    applyStimulus(scl, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 4);
    applyStimulus(1'b1, 1'b0, 4);
    applyStimulus(1'b0, 1'b0, 2);
  endtask

  task automatic i2cStop();
    applyStimulus(1'b0, 1'b0, 3);
    applyStimulus(1'b1, 1'b0, 4);
    applyStimulus(1'b1, 1'b1, 6);
  endtask

  // One bit: SCL low 6 cycles (optionally with SDA glitches), high 8 cycles.
  // With simul set, SDA moves to nextB in the same instant SCL falls.
  task automatic sendBit(input logic b, input bit glitch, input bit simul,
                         input logic nextB, output logic sampled);
    if (glitch) begin
      applyStimulus(1'b0, ~b, 1);
      applyStimulus(1'b0, b, 1);
      applyStimulus(1'b0, ~b, 1);
      applyStimulus(1'b0, b, 2);
    end else begin
      applyStimulus(1'b0, b, 5);
    end
    applyStimulus(1'b1, b, 4);
    sampled = sdaLine;
    applyStimulus(1'b1, b, 4);
    applyStimulus(1'b0, simul ? nextB : b, 1);
  endtask

  task automatic sendByte(input logic [7:0] v, input bit glitch, input bit simul,
                          output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      sendBit(v[i], glitch, simul, (i > 0) ? v[i-1] : 1'b1, s);
    end
    sendBit(1'b1, 1'b0, simul, 1'b1, s);
    ack = ~s;
  endtask

  // Full write transaction with reference checks: the target ACKs and
  // delivers every byte only when the address matches and R/W is 0
  task automatic runTxn(input logic [7:0] addrByte, input int n, input bit glitch,
                        input bit simul, input string tag);
    int   rx0, drv0, busy0, stop0;
    logic ack;
    logic expA;
    rx0   = rxCount;
    drv0  = driveCount;
    busy0 = busyCount;
    stop0 = stopCount;
    expA  = (addrByte[7:1] == SLAVE) && (addrByte[0] == 1'b0);
    i2cStart();
    sendByte(addrByte, glitch, simul, ack);
    checkOutput({tag, ".addrAck"}, 32'(ack), 32'(expA));
    checkOutput({tag, ".busyAfterAddr"}, 32'(busy), 32'(expA));
    for (int k = 0; k < n; k++) begin
      sendByte(txData[k], glitch, simul, ack);
      checkOutput({tag, ".dataAck"}, 32'(ack), 32'(expA));
    end
    i2cStop();
    checkOutput({tag, ".busyAfterStop"}, 32'(busy), 32'd0);
    checkOutput({tag, ".stopPulses"}, 32'(stopCount - stop0), 32'd1);
    checkOutput({tag, ".rxBytes"}, 32'(rxCount - rx0), expA ? 32'(n) : 32'd0);
    if (expA) begin
      for (int k = 0; k < n; k++) begin
        checkOutput({tag, ".rxData"}, 32'(rxLog[rx0 + k]), 32'(txData[k]));
      end
    end else begin
      checkOutput({tag, ".driveNever"}, 32'(driveCount - drv0), 32'd0);
      checkOutput({tag, ".busyNever"}, 32'(busyCount - busy0), 32'd0);
    end
  endtask

  initial begin
    logic       ack;
    logic       s;
    int         rx0;
    int         stop0;
    logic [6:0] addr;
    logic       rw;

    // Reset state
    repeat (4) @(negedge clk);
    checkOutput("reset.sdaDrive", 32'(sdaDrive), 32'd0);
    checkOutput("reset.dataOut", 32'(dataOut), 32'h00);
    checkOutput("reset.dataValid", 32'(dataValid), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.stopSeen", 32'(stopSeen), 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("postReset.noStop", 32'(stopCount), 32'd0);

    // Matching write with two bytes
    txData[0] = 8'hA5;
    txData[1] = 8'h3C;
    runTxn({SLAVE, 1'b0}, 2, 1'b0, 1'b0, "write2");

    // Address mismatch
    txData[0] = 8'hFF;
    runTxn({7'h49, 1'b0}, 1, 1'b0, 1'b0, "badAddr");

    // Read request to our address gets NACK and is ignored
    txData[0] = 8'h77;
    runTxn({SLAVE, 1'b1}, 1, 1'b0, 1'b0, "readReq");

    // Partial byte abandoned by a repeated START
    rx0 = rxCount;
    i2cStart();
    sendByte({SLAVE, 1'b0}, 1'b0, 1'b0, ack);
    checkOutput("partial.addrAck", 32'(ack), 32'd1);
    for (int i = 7; i >= 4; i--) begin
      sendBit(1'b1 ^ (i < 4), 1'b0, 1'b0, 1'b1, s);
    end
    i2cStart();
    checkOutput("partial.busyAfterRestart", 32'(busy), 32'd0);
    sendByte({SLAVE, 1'b0}, 1'b0, 1'b0, ack);
    checkOutput("partial.addrAck2", 32'(ack), 32'd1);
    sendByte(8'h11, 1'b0, 1'b0, ack);
    checkOutput("partial.dataAck", 32'(ack), 32'd1);
    i2cStop();
    checkOutput("partial.rxBytes", 32'(rxCount - rx0), 32'd1);
    checkOutput("partial.rxData", 32'(rxLog[rx0]), 32'h11);

    // Reset while the target holds SDA low during a data ACK
    rx0 = rxCount;
    i2cStart();
    sendByte({SLAVE, 1'b0}, 1'b0, 1'b0, ack);
    for (int i = 7; i >= 0; i--) begin
      sendBit(8'hC3 >> i, 1'b0, 1'b0, 1'b1, s);
    end
    applyStimulus(1'b0, 1'b1, 4);
    checkOutput("rstAck.driveBefore", 32'(sdaDrive), 32'd1);
    checkOutput("rstAck.rxData", 32'(rxLog[rx0]), 32'hC3);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstAck.sdaDrive", 32'(sdaDrive), 32'd0);
    checkOutput("rstAck.dataOut", 32'(dataOut), 32'h00);
    checkOutput("rstAck.dataValid", 32'(dataValid), 32'd0);
    checkOutput("rstAck.busy", 32'(busy), 32'd0);
    checkOutput("rstAck.stopSeen", 32'(stopSeen), 32'd0);
    reset = 1'b0;
    stop0 = stopCount;
    i2cStop();
    checkOutput("rstAck.idleStop", 32'(stopCount - stop0), 32'd1);
    txData[0] = 8'h5A;
    runTxn({SLAVE, 1'b0}, 1, 1'b0, 1'b0, "afterReset");

    // SDA glitches while SCL low and SDA edges coinciding with SCL falls
    txData[0] = 8'($urandom_range(0, 255));
    txData[1] = 8'($urandom_range(0, 255));
    runTxn({SLAVE, 1'b0}, 2, 1'b1, 1'b1, "edges");

    // Randomized transactions
    for (int t = 0; t < 16; t++) begin
      addr = ($urandom_range(0, 1) == 1) ? SLAVE : 7'($urandom_range(0, 127));
      rw   = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 4; k++) txData[k] = 8'($urandom_range(0, 255));
      runTxn({addr, rw}, $urandom_range(1, 3), $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, "random");
    end

    checkOutput("validWidth", 32'(validWidthErr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
